// File: rtl/even_odd_sorter.sv
// Splits an input stream into two FIFOs by parity (even / odd), each with its own valid/ready output.
// Optional macro EVEN_ODD_CNT_EN adds saturating 8-bit counters of accepted even and odd values.
module even_odd_sorter #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_number,
    output logic             in_ready,
    output logic             even_valid,
    output logic [WIDTH-1:0] even_number,
    input  logic             even_ready,
    output logic             odd_valid,
    output logic [WIDTH-1:0] odd_number,
    input  logic             odd_ready
`ifdef EVEN_ODD_CNT_EN
    ,
    output logic [7:0]       even_count,
    output logic [7:0]       odd_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // Pointers carry an extra wrap bit, so full and empty need no separate occupancy counter.
    logic [PW-1:0]    even_wr_q, even_wr_d, even_rd_q, even_rd_d;
    logic [PW-1:0]    odd_wr_q, odd_wr_d, odd_rd_q, odd_rd_d;
    logic [WIDTH-1:0] even_mem_q [DEPTH];
    logic [WIDTH-1:0] even_mem_d [DEPTH];
    logic [WIDTH-1:0] odd_mem_q [DEPTH];
    logic [WIDTH-1:0] odd_mem_d [DEPTH];

    logic even_full, odd_full, even_empty, odd_empty;
    logic is_odd, push_even, push_odd, pop_even, pop_odd;

    assign even_empty = (even_wr_q == even_rd_q);
    assign odd_empty  = (odd_wr_q == odd_rd_q);
    assign even_full  = (even_wr_q[PW-1] != even_rd_q[PW-1]) &&
                        (even_wr_q[AW-1:0] == even_rd_q[AW-1:0]);
    assign odd_full   = (odd_wr_q[PW-1] != odd_rd_q[PW-1]) &&
                        (odd_wr_q[AW-1:0] == odd_rd_q[AW-1:0]);

    // Full is judged on start-of-cycle occupancy, so a same-cycle pop never lets a push through.
    assign is_odd    = in_number[0];
    assign in_ready  = is_odd ? !odd_full : !even_full;
    assign push_even = in_valid && in_ready && !is_odd;
    assign push_odd  = in_valid && in_ready && is_odd;

    assign even_valid  = !even_empty;
    assign odd_valid   = !odd_empty;
    assign even_number = even_mem_q[even_rd_q[AW-1:0]];
    assign odd_number  = odd_mem_q[odd_rd_q[AW-1:0]];
    assign pop_even    = even_valid && even_ready;
    assign pop_odd     = odd_valid && odd_ready;

    always_comb begin
        even_wr_d = even_wr_q;
        even_rd_d = even_rd_q;
        odd_wr_d  = odd_wr_q;
        odd_rd_d  = odd_rd_q;
        even_mem_d = even_mem_q;
        odd_mem_d  = odd_mem_q;
        if (push_even) begin
            even_mem_d[even_wr_q[AW-1:0]] = in_number;
            even_wr_d = even_wr_q + PW'(1);
        end
        if (push_odd) begin
            odd_mem_d[odd_wr_q[AW-1:0]] = in_number;
            odd_wr_d = odd_wr_q + PW'(1);
        end
        if (pop_even) even_rd_d = even_rd_q + PW'(1);
        if (pop_odd)  odd_rd_d  = odd_rd_q + PW'(1);
    end

`ifdef EVEN_ODD_CNT_EN
    logic [7:0] even_count_q, even_count_d, odd_count_q, odd_count_d;

    // Counters stick at 255 rather than wrapping.
    always_comb begin
        even_count_d = even_count_q;
        odd_count_d  = odd_count_q;
        if (push_even && even_count_q != 8'hFF) even_count_d = even_count_q + 8'd1;
        if (push_odd && odd_count_q != 8'hFF)   odd_count_d  = odd_count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            even_count_q <= '0;
            odd_count_q  <= '0;
        end else begin
            even_count_q <= even_count_d;
            odd_count_q  <= odd_count_d;
        end
    end

    assign even_count = even_count_q;
    assign odd_count  = odd_count_q;
`endif

    // Storage is deliberately left out of reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            even_wr_q <= '0;
            even_rd_q <= '0;
            odd_wr_q  <= '0;
            odd_rd_q  <= '0;
        end else begin
            even_wr_q  <= even_wr_d;
            even_rd_q  <= even_rd_d;
            odd_wr_q   <= odd_wr_d;
            odd_rd_q   <= odd_rd_d;
            even_mem_q <= even_mem_d;
            odd_mem_q  <= odd_mem_d;
        end
    end

endmodule

// File: tb/tb_even_odd_sorter.sv
// Bench for even_odd_sorter: directed scenarios plus a random run, checked by an occupancy model
// and per-class expected queues drained by a separate output monitor.
module tb_even_odd_sorter;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_number;
  logic             in_ready;
  logic             even_valid, odd_valid;
  logic [WIDTH-1:0] even_number, odd_number;
  logic             even_ready, odd_ready;
`ifdef EVEN_ODD_CNT_EN
  logic [7:0]       even_count, odd_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] exp_even_q[$];
  logic [WIDTH-1:0] exp_odd_q[$];
  int m_even = 0;
  int m_odd = 0;
  int m_even_acc = 0;
  int m_odd_acc = 0;

  even_odd_sorter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_number   (in_number),
    .in_ready    (in_ready),
    .even_valid  (even_valid),
    .even_number (even_number),
    .even_ready  (even_ready),
    .odd_valid   (odd_valid),
    .odd_number  (odd_number),
    .odd_ready   (odd_ready)
`ifdef EVEN_ODD_CNT_EN
    ,
    .even_count  (even_count),
    .odd_count   (odd_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // stimulus issue point: 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model: occupancy, predicted in_ready and expected-queue pushes, sampled at negedge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_even_q.delete();
      exp_odd_q.delete();
      m_even = 0;
      m_odd = 0;
      m_even_acc = 0;
      m_odd_acc = 0;
    end else begin
      logic pred_ready, acc, ev_pop, od_pop;
      pred_ready = in_number[0] ? (m_odd < DEPTH) : (m_even < DEPTH);
      chk("model_in_ready", 32'(in_ready), 32'(pred_ready));
      chk("model_even_valid", 32'(even_valid), 32'(m_even > 0));
      chk("model_odd_valid", 32'(odd_valid), 32'(m_odd > 0));
`ifdef EVEN_ODD_CNT_EN
      chk("model_even_count", 32'(even_count), 32'((m_even_acc > 255) ? 255 : m_even_acc));
      chk("model_odd_count", 32'(odd_count), 32'((m_odd_acc > 255) ? 255 : m_odd_acc));
`endif
      ev_pop = (m_even > 0) && even_ready;
      od_pop = (m_odd > 0) && odd_ready;
      acc = in_valid && pred_ready;
      if (acc && !in_number[0]) begin
        exp_even_q.push_back(in_number);
        m_even++;
        m_even_acc++;
      end
      if (acc && in_number[0]) begin
        exp_odd_q.push_back(in_number);
        m_odd++;
        m_odd_acc++;
      end
      if (ev_pop) m_even--;
      if (od_pop) m_odd--;
    end
  end

  // output monitor: every DUT pop is compared with the head of its expected queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (even_valid && even_ready) begin
        if (exp_even_q.size() == 0) chk("even_unexpected_pop", 32'(even_number), 32'hFFFF_FFFF);
        else chk("even_data", 32'(even_number), 32'(exp_even_q.pop_front()));
      end
      if (odd_valid && odd_ready) begin
        if (exp_odd_q.size() == 0) chk("odd_unexpected_pop", 32'(odd_number), 32'hFFFF_FFFF);
        else chk("odd_data", 32'(odd_number), 32'(exp_odd_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_number = '0;
    even_ready = 1'b0;
    odd_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    chk("reset_even_valid", 32'(even_valid), 0);
    chk("reset_odd_valid", 32'(odd_valid), 0);
    chk("reset_in_ready", 32'(in_ready), 1);

    // back-to-back 6, 3, 0, 9 with both readies high
    even_ready = 1'b1;
    odd_ready = 1'b1;
    in_valid = 1'b1;
    in_number = 4'd6;
    step();
    in_number = 4'd3;
    chk("b2b_6_valid", 32'(even_valid), 1);
    chk("b2b_6_data", 32'(even_number), 6);
    step();
    in_number = 4'd0;
    chk("b2b_3_valid", 32'(odd_valid), 1);
    chk("b2b_3_data", 32'(odd_number), 3);
    chk("b2b_6_drained", 32'(even_valid), 0);
    step();
    in_number = 4'd9;
    chk("b2b_0_valid", 32'(even_valid), 1);
    chk("b2b_0_data", 32'(even_number), 0);
    step();
    in_valid = 1'b0;
    chk("b2b_9_valid", 32'(odd_valid), 1);
    chk("b2b_9_data", 32'(odd_number), 9);
    repeat (2) step();

    // even FIFO full stalls 10 but not odd 5
    even_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_number = 4'(2 * i);
      #1;
      chk("fill_in_ready", 32'(in_ready), 1);
      step();
    end
    in_number = 4'd10;
    #1;
    chk("full_10_in_ready", 32'(in_ready), 0);
    chk("full_head", 32'(even_number), 2);
    step();
    chk("full_10_still_stalled", 32'(in_ready), 0);
    in_number = 4'd5;
    #1;
    chk("odd_5_in_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("odd_5_valid", 32'(odd_valid), 1);
    chk("odd_5_data", 32'(odd_number), 5);
    step();
    chk("full_head_held", 32'(even_number), 2);

    // full FIFO with same-cycle pop: 12 waits one cycle
    in_valid = 1'b1;
    in_number = 4'd12;
    even_ready = 1'b1;
    #1;
    chk("nopass_12_in_ready", 32'(in_ready), 0);
    step();
    chk("nopass_12_next_ready", 32'(in_ready), 1);
    chk("nopass_head_4", 32'(even_number), 4);
    step();
    in_valid = 1'b0;
    chk("after_12_head", 32'(even_number), 6);
    repeat (4) step();
    chk("drained_even_valid", 32'(even_valid), 0);

    // reset mid-operation discards 1, 3, 5 and the handshake in the reset cycle
    odd_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_number = 4'(2 * i + 1);
      step();
    end
    chk("pre_reset_odd_valid", 32'(odd_valid), 1);
    in_number = 4'd7;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("post_reset_odd_valid", 32'(odd_valid), 0);
    chk("post_reset_even_valid", 32'(even_valid), 0);
    chk("post_reset_in_ready", 32'(in_ready), 1);
`ifdef EVEN_ODD_CNT_EN
    chk("post_reset_even_count", 32'(even_count), 0);
    chk("post_reset_odd_count", 32'(odd_count), 0);
`endif
    in_valid = 1'b0;
    step();
    chk("reset_handshake_dropped", 32'(odd_valid), 0);

    // 300 even values: counter saturation
    even_ready = 1'b1;
    odd_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_number = 4'((2 * i) % 16);
      step();
    end
    in_valid = 1'b0;
    step();
`ifdef EVEN_ODD_CNT_EN
    chk("sat_even_count", 32'(even_count), 255);
    chk("sat_odd_count", 32'(odd_count), 0);
`endif

    // random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_number = 4'($urandom_range(0, 15));
      even_ready = ($urandom_range(0, 3) != 0);
      odd_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    in_valid = 1'b0;
    even_ready = 1'b1;
    odd_ready = 1'b1;
    repeat (2 * DEPTH + 2) step();
    chk("final_even_queue_empty", 32'(exp_even_q.size()), 0);
    chk("final_odd_queue_empty", 32'(exp_odd_q.size()), 0);
    chk("final_even_valid", 32'(even_valid), 0);
    chk("final_odd_valid", 32'(odd_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/even_odd_sorter.md
EVEN_ODD_SORTER -- requirements
Module: even_odd_sorter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: bit width of each number.
REQ-002 The block SHALL have parameter DEPTH, default 4: entries per output FIFO, a power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream number present.
REQ-006 The block SHALL have port in_number, input, WIDTH bits: unsigned number to classify.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_number this cycle.
REQ-008 The block SHALL have port even_valid, output, 1 bit: the even FIFO head is valid.
REQ-009 The block SHALL have port even_number, output, WIDTH bits: the even FIFO head.
REQ-010 The block SHALL have port even_ready, input, 1 bit: the downstream consumer pops the even FIFO.
REQ-011 The block SHALL have port odd_valid, output, 1 bit: the odd FIFO head is valid.
REQ-012 The block SHALL have port odd_number, output, WIDTH bits: the odd FIFO head.
REQ-013 The block SHALL have port odd_ready, input, 1 bit: the downstream consumer pops the odd FIFO.
REQ-014 The block SHALL have port even_count, output, 8 bits: number of accepted even values (present only under EVEN_ODD_CNT_EN).
REQ-015 The block SHALL have port odd_count, output, 8 bits: number of accepted odd values (present only under EVEN_ODD_CNT_EN).

Function
REQ-016 A number SHALL be classified as even when in_number[0]==0 and odd otherwise; zero is even.
REQ-017 in_ready SHALL be high exactly when the FIFO selected by in_number[0] is not full, judged by its occupancy at the start of the cycle.
REQ-018 A value SHALL be accepted on a rising edge where in_valid && in_ready; it is pushed into the tail of the selected FIFO only, and order within each FIFO is preserved.
REQ-019 A full FIFO SHALL NOT accept a push even when the same-cycle pop frees an entry (no full-cycle passthrough).
REQ-020 A full even FIFO SHALL NOT stall odd values, and a full odd FIFO SHALL NOT stall even values.
REQ-021 even_valid SHALL equal even FIFO not-empty, and odd_valid SHALL equal odd FIFO not-empty.
REQ-022 even_number and odd_number SHALL present the FIFO head directly from storage, and SHALL hold stable while valid is high and ready is low.
REQ-023 A pop SHALL occur on a rising edge with valid && ready; ready while empty SHALL be ignored with no underflow.
REQ-024 Latency SHALL be 1 cycle: a value accepted at edge N drives valid at that output after edge N when the FIFO was empty.
REQ-025 A simultaneous push and pop on a non-empty, non-full FIFO SHALL leave occupancy unchanged; on an empty FIFO, the head becomes the pushed value.
REQ-026 Read and write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full is defined as MSBs differ and the rest equal, and empty as pointers equal.
REQ-027 With the counters compiled in, each accepted even value SHALL increment even_count and each accepted odd value SHALL increment odd_count, saturating at 255 with no wrap.

Reset
REQ-028 While rst_n==0 at a rising edge, both FIFOs SHALL be emptied (pointers cleared), even_valid and odd_valid SHALL be 0, and even_count and odd_count SHALL be 0.
REQ-029 even_number and odd_number SHALL be don't-care during reset, and stored data SHALL NOT be cleared.
REQ-030 A reset mid-operation SHALL discard all buffered values, and any in_valid handshake in that cycle SHALL NOT be accepted.
REQ-031 After rst_n rises, in_ready SHALL be 1 on the first cycle.

Configuration
REQ-032 With macro EVEN_ODD_CNT_EN defined, the ports even_count and odd_count and their saturating counters SHALL exist as specified.
REQ-033 Without EVEN_ODD_CNT_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 The bench SHALL drive in_number 6, 3, 0, 9 back-to-back with both readies high, and SHALL check even outputs 6 then 0, odd outputs 3 then 9, each 1 cycle after acceptance.
REQ-035 The bench SHALL hold even_ready=0, push evens 2, 4, 6, 8, then drive 10, and SHALL check that in_ready falls while 10 is presented, while a subsequent odd value 5 is accepted immediately.
REQ-036 The bench SHALL fill the even FIFO, drive 12 with even_ready=1 in the same cycle, and SHALL check that 12 is not accepted in that cycle and is accepted on the next.
REQ-037 The bench SHALL push 1, 3, 5, then assert rst_n=0 for 1 cycle, and SHALL check odd_valid=0, counts=0, and in_ready=1 after release.
REQ-038 The bench, with EVEN_ODD_CNT_EN defined, SHALL push 300 even values with even_ready=1, and SHALL check even_count=255 and odd_count=0.
REQ-039 The bench SHALL drive random in_valid, even_ready and odd_ready for 10k cycles against a reference model, and SHALL check no loss, no duplication and per-class order.
